// File: rtl/forth_pkg.sv
// ---------------------------------------------------------------------------
// forth_pkg
//   Shared definitions for the Forth tokenizer front end.
//   - tok_state_t : tokenizer FSM states (SKIP, COLLECT, HOLD)
//   - CH_SP, CH_TAB, CH_LF, CH_CR : the four word-separating characters
//   - is_delim()  : true when an 8-bit character is one of the separators
// ---------------------------------------------------------------------------
package forth_pkg;

    typedef enum logic [1:0] {
        SKIP    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } tok_state_t;

    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;

    // Only these four codes separate words; every other value, NUL included,
    // is an ordinary word character.
    function automatic logic is_delim(input logic [7:0] ch);
        return (ch == CH_SP) || (ch == CH_TAB) || (ch == CH_LF) || (ch == CH_CR);
    endfunction

endpackage

// File: rtl/forth_tokenizer.sv
// ---------------------------------------------------------------------------
// forth_tokenizer
//   Splits a character stream into zero-padded fixed-width word keys for the
//   dictionary index search. Each finished word is presented with a
//   valid/ready handshake and a one-cycle update strobe.
//
// Parameters
//   KEY_WIDTH  : bits per character (must be >= 8)
//   KEY_LENGTH : maximum characters per key
//   LEN_BITS   : derived width of the length count
//
// Ports
//   i_clk        in   clock, rising edge
//   i_reset      in   asynchronous active-high reset
//   i_char_valid in   i_char is valid this cycle
//   i_char       in   input character
//   o_char_ready out  character accepted this cycle (state != HOLD)
//   o_key        out  word buffer, first character in o_key[0], unused = 0
//   o_length     out  number of stored characters, 0..KEY_LENGTH
//   o_overflow   out  word was longer than KEY_LENGTH and was truncated
//   o_valid      out  o_key/o_length/o_overflow hold a complete word
//   i_ready      in   downstream consumes the held word
//   o_update     out  one-cycle pulse on the first cycle of o_valid
// ---------------------------------------------------------------------------
module forth_tokenizer
    import forth_pkg::*;
#(
    parameter  int KEY_WIDTH  = 8,
    parameter  int KEY_LENGTH = 8,
    localparam int LEN_BITS   = $clog2(KEY_LENGTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_char_valid,
    input  logic [KEY_WIDTH-1:0] i_char,
    output logic                 o_char_ready,
    output logic [KEY_WIDTH-1:0] o_key [KEY_LENGTH-1:0],
    output logic [LEN_BITS-1:0]  o_length,
    output logic                 o_overflow,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_update
);

    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(KEY_LENGTH);

    tok_state_t           state_reg,    state_next;
    logic [LEN_BITS-1:0]  length_reg,   length_next;
    logic                 overflow_reg, overflow_next;
    logic                 update_reg,   update_next;
    logic [KEY_WIDTH-1:0] key_reg [KEY_LENGTH-1:0];

    logic high_zero;
    logic char_delim;
    logic char_fire;
    logic store_en;
    logic release_word;

    // With characters wider than a byte, a separator must also have all of
    // its upper bits clear.
    generate
        if (KEY_WIDTH > 8) begin : g_wide
            assign high_zero = (i_char[KEY_WIDTH-1:8] == '0);
        end else begin : g_byte
            assign high_zero = 1'b1;
        end
    endgenerate

    assign char_delim   = is_delim(i_char[7:0]) && high_zero;
    assign char_fire    = i_char_valid && (state_reg != HOLD);
    assign release_word = (state_reg == HOLD) && i_ready;

    // Slot to write is always the current length: in SKIP the length is 0,
    // so the first character lands in slot 0 without a separate path.
    assign store_en = char_fire && !char_delim &&
                      ((state_reg == SKIP) ||
                       ((state_reg == COLLECT) && (length_reg < MAX_LEN)));

    always_comb begin
        state_next    = state_reg;
        length_next   = length_reg;
        overflow_next = overflow_reg;
        update_next   = 1'b0;
        case (state_reg)
            SKIP: begin
                if (char_fire && !char_delim) begin
                    state_next  = COLLECT;
                    length_next = LEN_BITS'(1);
                end
            end
            COLLECT: begin
                if (char_fire) begin
                    if (char_delim) begin
                        state_next  = HOLD;
                        // Flag marks HOLD entry; it lives for exactly one cycle.
                        update_next = 1'b1;
                    end else if (length_reg < MAX_LEN) begin
                        length_next = length_reg + LEN_BITS'(1);
                    end else begin
                        // Saturate the count and remember the truncation.
                        overflow_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (i_ready) begin
                    state_next    = SKIP;
                    length_next   = '0;
                    overflow_next = 1'b0;
                end
            end
            default: begin
                state_next    = SKIP;
                length_next   = '0;
                overflow_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= SKIP;
            length_reg   <= '0;
            overflow_reg <= 1'b0;
            update_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            length_reg   <= length_next;
            overflow_reg <= overflow_next;
            update_reg   <= update_next;
        end
    end

    // Word buffer. Clearing on release guarantees the next word starts from
    // an all-zero key, so short words never carry stale characters.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < KEY_LENGTH; i++) begin
                key_reg[i] <= '0;
            end
        end else if (release_word) begin
            for (int i = 0; i < KEY_LENGTH; i++) begin
                key_reg[i] <= '0;
            end
        end else if (store_en) begin
            for (int i = 0; i < KEY_LENGTH; i++) begin
                if (length_reg == LEN_BITS'(i)) begin
                    key_reg[i] <= i_char;
                end
            end
        end
    end

    assign o_char_ready = (state_reg != HOLD);
    assign o_valid      = (state_reg == HOLD);
    assign o_update     = update_reg;
    assign o_length     = length_reg;
    assign o_overflow   = overflow_reg;
    assign o_key        = key_reg;

endmodule

// File: tb/tb_forth_tokenizer.sv
// ---------------------------------------------------------------------------
// tb_forth_tokenizer
//   Self-checking bench for forth_tokenizer: word table, hand-written
//   multi-cycle sequences and a randomized stream compared every cycle with a
//   word-level reference model.
// ---------------------------------------------------------------------------
module tb_forth_tokenizer;

    localparam int KW = 8;
    localparam int KL = 8;
    localparam int LB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          char_valid = 1'b0;
    logic [KW-1:0] char_in = '0;
    logic          char_ready;
    logic [KW-1:0] key [KL-1:0];
    logic [LB-1:0] length;
    logic          overflow;
    logic          valid;
    logic          ready_in = 1'b1;
    logic          update;

    forth_tokenizer #(.KEY_WIDTH(KW), .KEY_LENGTH(KL)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_char_valid (char_valid),
        .i_char       (char_in),
        .o_char_ready (char_ready),
        .o_key        (key),
        .o_length     (length),
        .o_overflow   (overflow),
        .o_valid      (valid),
        .i_ready      (ready_in),
        .o_update     (update)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_ws(input logic [7:0] c);
        return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
    endfunction

    function automatic logic [63:0] str_key(input string w);
        logic [63:0] k = '0;
        for (int i = 0; i < w.len() && i < KL; i++) k[8*i +: 8] = w[i];
        return k;
    endfunction

    function automatic logic [63:0] dut_key();
        logic [63:0] k;
        for (int i = 0; i < KL; i++) k[8*i +: 8] = key[i];
        return k;
    endfunction

    // ---------------- reference model: the word text itself ----------------
    byte unsigned m_word[$];
    bit m_hold  = 1'b0;
    bit m_first = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_word.delete();
            m_hold  = 1'b0;
            m_first = 1'b0;
        end else if (m_hold) begin
            m_first = 1'b0;
            if (ready_in) begin
                m_hold = 1'b0;
                m_word.delete();
            end
        end else if (char_valid) begin
            if (is_ws(char_in)) begin
                if (m_word.size() > 0) begin
                    m_hold  = 1'b1;
                    m_first = 1'b1;
                end
            end else begin
                m_word.push_back(char_in);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [63:0] ek;
            int          n;
            ek = '0;
            n  = m_word.size();
            for (int i = 0; i < KL && i < n; i++) ek[8*i +: 8] = m_word[i];
            chk("model_ready",    char_ready, !m_hold);
            chk("model_valid",    valid,      m_hold);
            chk("model_update",   update,     m_hold && m_first);
            chk("model_length",   length,     (n > KL) ? KL : n);
            chk("model_overflow", overflow,   n > KL);
            chk("model_key",      dut_key(),  ek);
        end
    end

    // ---------------- captured words (on o_update) ----------------
    typedef struct { logic [63:0] key; int len; bit ovf; } cap_t;
    cap_t cap_q[$];

    always @(negedge clk) begin
        if (update) cap_q.push_back('{dut_key(), int'(length), overflow});
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_char(input logic [7:0] c);
        bit acc = 1'b0;
        char_valid = 1'b1;
        char_in    = c;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk);
            acc = char_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("char_accept_timeout", 0, 1);
    endtask

    task automatic send_string(input string s);
        for (int i = 0; i < s.len(); i++) drive_char(s[i]);
        char_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        char_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_word(input string tag, input int idx, input string w, input int len, input bit ovf);
        if (cap_q.size() > idx) begin
            chk({tag, "_key"}, cap_q[idx].key, str_key(w));
            chk({tag, "_len"}, cap_q[idx].len, len);
            chk({tag, "_ovf"}, cap_q[idx].ovf, ovf);
        end else begin
            chk({tag, "_missing"}, cap_q.size(), idx + 1);
        end
    endtask

    typedef struct { string text; string word; int len; bit ovf; } vec_t;
    vec_t vecs[6];

    logic [7:0] delims[4] = '{8'h20, 8'h09, 8'h0A, 8'h0D};
    int vcyc[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"  DUP ",         "DUP",      3, 1'b0};
        vecs[1] = '{"ABCDEFGHIJ ",    "ABCDEFGH", 8, 1'b1};
        vecs[2] = '{"ABCDEFGH ",      "ABCDEFGH", 8, 1'b0};
        vecs[3] = '{"ABCDEFGHI\t",    "ABCDEFGH", 8, 1'b1};
        vecs[4] = '{"\t\n\015 X\015", "X",        1, 1'b0};
        vecs[5] = '{"a1!~\n",         "a1!~",     4, 1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready",    char_ready, 1);
        chk("reset_valid",    valid,      0);
        chk("reset_update",   update,     0);
        chk("reset_length",   length,     0);
        chk("reset_overflow", overflow,   0);
        chk("reset_key",      dut_key(),  0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Table of single words
        ready_in = 1'b1;
        for (int v = 0; v < 6; v++) begin
            cap_q.delete();
            send_string(vecs[v].text);
            idle(3);
            chk($sformatf("vec%0d_count", v), cap_q.size(), 1);
            chk_word($sformatf("vec%0d", v), 0, vecs[v].word, vecs[v].len, vecs[v].ovf);
        end

        // Runs of mixed separators between two one-character words
        cap_q.delete();
        send_string("1\t\n\015 \015\t2 ");
        idle(3);
        chk("delim_run_count", cap_q.size(), 2);
        chk_word("delim_run_w0", 0, "1", 1, 1'b0);
        chk_word("delim_run_w1", 1, "2", 1, 1'b0);

        // Stall: word held with i_ready low, next character waits
        cap_q.delete();
        ready_in = 1'b0;
        send_string("A ");
        char_valid = 1'b1;
        char_in    = "B";
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_ready_low", char_ready, 0);
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        send_string("B ");
        idle(3);
        chk("stall_count", cap_q.size(), 2);
        chk_word("stall_w0", 0, "A", 1, 1'b0);
        chk_word("stall_w1", 1, "B", 1, 1'b0);

        // Asynchronous reset in the middle of a word
        cap_q.delete();
        drive_char("X");
        drive_char("Y");
        char_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_key",      dut_key(), 0);
        chk("async_rst_length",   length,    0);
        chk("async_rst_overflow", overflow,  0);
        chk("async_rst_valid",    valid,     0);
        chk("async_rst_update",   update,    0);
        chk("async_rst_ready",    char_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("async_rst_no_update", cap_q.size(), 0);
        send_string("Z ");
        idle(3);
        chk("after_rst_count", cap_q.size(), 1);
        chk_word("after_rst", 0, "Z", 1, 1'b0);

        // Continuous stream: o_valid expected in cycles 3 and 7
        cap_q.delete();
        vcyc.delete();
        fork
            send_string("AB CD ");
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (valid) vcyc.push_back(k);
                end
            end
        join
        idle(2);
        chk("stream_valid_count", vcyc.size(), 2);
        chk("stream_valid_first",  (vcyc.size() > 0) ? vcyc[0] : -1, 3);
        chk("stream_valid_second", (vcyc.size() > 1) ? vcyc[1] : -1, 7);
        chk_word("stream_w0", 0, "AB", 2, 1'b0);
        chk_word("stream_w1", 1, "CD", 2, 1'b0);

        // Randomized stream against the model; second half favours long words
        for (int n = 0; n < 3000; n++) begin
            int dprob;
            int r;
            dprob      = (n < 1500) ? 30 : 6;
            char_valid = ($urandom_range(0, 3) != 0);
            r          = $urandom_range(0, 99);
            if (r < dprob)          char_in = delims[$urandom_range(0, 3)];
            else if (r < dprob + 3) char_in = 8'h00;
            else                    char_in = 8'(8'h21 + $urandom_range(0, 93));
            ready_in = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        idle(5);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
